// File: rtl/fetch_thread_ctrl.sv
// Multithreaded IF-stage fetch controller: round-robin thread select, per-thread miss waits,
// and a small MSHR queue that coalesces line misses and issues them to memory.
module fetch_thread_ctrl #(
  parameter int unsigned N_THREADS  = 4,
  parameter int unsigned PADDR_W    = 20,
  parameter int unsigned LINE_OFF_W = 4,
  parameter int unsigned MSHR_DEPTH = 2,
  localparam int unsigned TID_W     = $clog2(N_THREADS),
  localparam int unsigned MIDX_W    = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1,
  localparam int unsigned LINE_W    = PADDR_W - LINE_OFF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [TID_W-1:0]     fetch_thread,
  output logic                 fetch_valid,
  input  logic                 miss_en,
  input  logic [PADDR_W-1:0]   miss_addr,
  input  logic                 exc_en,
  input  logic [TID_W-1:0]     exc_thread,
  output logic                 mem_req_ren,
  output logic [PADDR_W-1:0]   mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rec_en,
  input  logic [PADDR_W-1:0]   mem_rec_addr,
  output logic [N_THREADS-1:0] stalled,
  output logic                 mshr_full
);

  typedef enum logic {StReady, StWaitMem} th_state_e;

  th_state_e            th_state_q [N_THREADS];
  th_state_e            th_state_d [N_THREADS];
  logic [MIDX_W-1:0]    th_idx_q   [N_THREADS];
  logic [MIDX_W-1:0]    th_idx_d   [N_THREADS];

  logic [MSHR_DEPTH-1:0] mshr_valid_q, mshr_valid_d;
  logic [MSHR_DEPTH-1:0] mshr_issued_q, mshr_issued_d;
  logic [LINE_W-1:0]     mshr_line_q [MSHR_DEPTH];
  logic [LINE_W-1:0]     mshr_line_d [MSHR_DEPTH];

  logic [TID_W-1:0]   fetch_thread_q, fetch_thread_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               req_ren_q, req_ren_d;
  logic [PADDR_W-1:0] req_addr_q, req_addr_d;
  logic [MIDX_W-1:0]  req_idx_q, req_idx_d;
  logic               mshr_full_q, mshr_full_d;

  logic [LINE_W-1:0]  line_miss, line_rec;
  logic               rec_hit, miss_live, miss_done, issue_found, sched_found;
  logic [MIDX_W-1:0]  rec_idx;
  int unsigned        cand;

  // Offset bits of both addresses are irrelevant at line granularity.
  logic unused_off;
  assign unused_off = ^{miss_addr[LINE_OFF_W-1:0], mem_rec_addr[LINE_OFF_W-1:0]};

  assign line_miss = miss_addr[PADDR_W-1:LINE_OFF_W];
  assign line_rec  = mem_rec_addr[PADDR_W-1:LINE_OFF_W];

  always_comb begin
    th_state_d     = th_state_q;
    th_idx_d       = th_idx_q;
    mshr_valid_d   = mshr_valid_q;
    mshr_issued_d  = mshr_issued_q;
    mshr_line_d    = mshr_line_q;
    fetch_thread_d = fetch_thread_q;
    fetch_valid_d  = 1'b0;
    req_ren_d      = req_ren_q;
    req_addr_d     = req_addr_q;
    req_idx_d      = req_idx_q;
    rec_hit        = 1'b0;
    rec_idx        = '0;
    miss_done      = 1'b0;
    issue_found    = 1'b0;
    sched_found    = 1'b0;
    cand           = 0;

    // Response: free the matching issued entry and release its waiters.
    for (int e = 0; e < MSHR_DEPTH; e++) begin
      if (!rec_hit && mem_rec_en && mshr_valid_q[e] && mshr_issued_q[e] &&
          mshr_line_q[e] == line_rec) begin
        rec_hit = 1'b1;
        rec_idx = MIDX_W'(e);
      end
    end
    if (rec_hit) begin
      mshr_valid_d[rec_idx]  = 1'b0;
      mshr_issued_d[rec_idx] = 1'b0;
      for (int t = 0; t < N_THREADS; t++) begin
        if (th_state_q[t] == StWaitMem && th_idx_q[t] == rec_idx) th_state_d[t] = StReady;
      end
    end

    // Exception: the entry stays allocated since its response is still coming.
    for (int t = 0; t < N_THREADS; t++) begin
      if (exc_en && TID_W'(t) == exc_thread) th_state_d[t] = StReady;
    end

    miss_live = miss_en && fetch_valid_q && !(exc_en && exc_thread == fetch_thread_q);
    if (miss_live && !(mem_rec_en && line_miss == line_rec)) begin
      for (int e = 0; e < MSHR_DEPTH; e++) begin
        if (!miss_done && mshr_valid_d[e] && mshr_line_d[e] == line_miss) begin
          miss_done = 1'b1;
          for (int t = 0; t < N_THREADS; t++) begin
            if (TID_W'(t) == fetch_thread_q) begin
              th_state_d[t] = StWaitMem;
              th_idx_d[t]   = MIDX_W'(e);
            end
          end
        end
      end
      for (int e = 0; e < MSHR_DEPTH; e++) begin
        if (!miss_done && !mshr_valid_d[e]) begin
          miss_done        = 1'b1;
          mshr_valid_d[e]  = 1'b1;
          mshr_issued_d[e] = 1'b0;
          mshr_line_d[e]   = line_miss;
          for (int t = 0; t < N_THREADS; t++) begin
            if (TID_W'(t) == fetch_thread_q) begin
              th_state_d[t] = StWaitMem;
              th_idx_d[t]   = MIDX_W'(e);
            end
          end
        end
      end
    end

    // Issue: after an accept, ren drops for a cycle before the next entry goes out.
    if (req_ren_q) begin
      if (mem_req_ready) begin
        mshr_issued_d[req_idx_q] = 1'b1;
        req_ren_d                = 1'b0;
      end
    end else begin
      for (int e = 0; e < MSHR_DEPTH; e++) begin
        if (!issue_found && mshr_valid_d[e] && !mshr_issued_d[e]) begin
          issue_found = 1'b1;
          req_ren_d   = 1'b1;
          req_addr_d  = {mshr_line_d[e], {LINE_OFF_W{1'b0}}};
          req_idx_d   = MIDX_W'(e);
        end
      end
    end

    for (int i = 1; i <= N_THREADS; i++) begin
      cand = (int'(fetch_thread_q) + i) % N_THREADS;
      if (!sched_found && th_state_d[cand] == StReady) begin
        sched_found    = 1'b1;
        fetch_thread_d = TID_W'(cand);
      end
    end
    fetch_valid_d = sched_found;
    mshr_full_d   = &mshr_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        th_state_q[t] <= StReady;
        th_idx_q[t]   <= '0;
      end
      for (int e = 0; e < MSHR_DEPTH; e++) mshr_line_q[e] <= '0;
      mshr_valid_q   <= '0;
      mshr_issued_q  <= '0;
      fetch_thread_q <= TID_W'(N_THREADS - 1);
      fetch_valid_q  <= 1'b0;
      req_ren_q      <= 1'b0;
      req_addr_q     <= '0;
      req_idx_q      <= '0;
      mshr_full_q    <= 1'b0;
    end else begin
      th_state_q     <= th_state_d;
      th_idx_q       <= th_idx_d;
      mshr_line_q    <= mshr_line_d;
      mshr_valid_q   <= mshr_valid_d;
      mshr_issued_q  <= mshr_issued_d;
      fetch_thread_q <= fetch_thread_d;
      fetch_valid_q  <= fetch_valid_d;
      req_ren_q      <= req_ren_d;
      req_addr_q     <= req_addr_d;
      req_idx_q      <= req_idx_d;
      mshr_full_q    <= mshr_full_d;
    end
  end

  always_comb begin
    for (int t = 0; t < N_THREADS; t++) stalled[t] = (th_state_q[t] == StWaitMem);
  end

  assign fetch_thread = fetch_thread_q;
  assign fetch_valid  = fetch_valid_q;
  assign mem_req_ren  = req_ren_q;
  assign mem_req_addr = req_addr_q;
  assign mshr_full    = mshr_full_q;

endmodule

// File: tb/tb_fetch_thread_ctrl.sv
// Directed, table-driven bench for fetch_thread_ctrl with default parameters.
module tb_fetch_thread_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  fetch_thread;
  logic        fetch_valid;
  logic        miss_en = 1'b0;
  logic [19:0] miss_addr = '0;
  logic        exc_en = 1'b0;
  logic [1:0]  exc_thread = '0;
  logic        mem_req_ren;
  logic [19:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rec_en = 1'b0;
  logic [19:0] mem_rec_addr = '0;
  logic [3:0]  stalled;
  logic        mshr_full;

  int checks = 0;
  int errors = 0;

  fetch_thread_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_thread (fetch_thread),
    .fetch_valid  (fetch_valid),
    .miss_en      (miss_en),
    .miss_addr    (miss_addr),
    .exc_en       (exc_en),
    .exc_thread   (exc_thread),
    .mem_req_ren  (mem_req_ren),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rec_en   (mem_rec_en),
    .mem_rec_addr (mem_rec_addr),
    .stalled      (stalled),
    .mshr_full    (mshr_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [19:0] maddr;
    logic        exc;
    logic [1:0]  ethr;
    logic        rdy;
    logic        rec;
    logic [19:0] raddr;
    logic [1:0]  ft;
    logic        fv;
    logic [3:0]  st;
    logic        ren;
    logic [19:0] addr;
    logic        full;
  } vec_t;

  localparam int NV = 44;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic m, input logic [19:0] ma, input logic x,
                              input logic [1:0] xt, input logic r, input logic rc,
                              input logic [19:0] ra, input logic [1:0] ft, input logic fv,
                              input logic [3:0] st, input logic ren, input logic [19:0] ad,
                              input logic fl);
    vec_t v;
    v.miss = m;  v.maddr = ma; v.exc = x;  v.ethr = xt; v.rdy = r;  v.rec = rc;
    v.raddr = ra; v.ft = ft;   v.fv = fv;  v.st = st;   v.ren = ren; v.addr = ad;
    v.full = fl;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic check_outs(input int idx, input logic [1:0] ft, input logic fv,
                            input logic [3:0] st, input logic ren, input logic [19:0] ad,
                            input logic fl);
    chk("fetch_thread", idx, 32'(fetch_thread), 32'(ft));
    chk("fetch_valid",  idx, 32'(fetch_valid),  32'(fv));
    chk("stalled",      idx, 32'(stalled),      32'(st));
    chk("mem_req_ren",  idx, 32'(mem_req_ren),  32'(ren));
    chk("mem_req_addr", idx, 32'(mem_req_addr), 32'(ad));
    chk("mshr_full",    idx, 32'(mshr_full),    32'(fl));
  endtask

  task automatic idle_inputs();
    miss_en = 1'b0; miss_addr = '0; exc_en = 1'b0; exc_thread = '0;
    mem_req_ready = 1'b0; mem_rec_en = 1'b0; mem_rec_addr = '0;
  endtask

  initial begin
    //              miss maddr     exc thr rdy rec raddr    | ft fv stalled  ren addr      full
    vecs[0]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     0, 1, 4'b0000, 0, 20'h00000, 0);
    vecs[1]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     1, 1, 4'b0000, 0, 20'h00000, 0);
    vecs[2]  = mk(1, 20'h01234, 0, 0, 0, 0, 20'h0,     2, 1, 4'b0010, 1, 20'h01230, 0);
    vecs[3]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     3, 1, 4'b0010, 1, 20'h01230, 0);
    vecs[4]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     0, 1, 4'b0010, 1, 20'h01230, 0);
    vecs[5]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     2, 1, 4'b0010, 1, 20'h01230, 0);
    vecs[6]  = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     3, 1, 4'b0010, 0, 20'h01230, 0);
    vecs[7]  = mk(0, 20'h0,     0, 0, 0, 1, 20'h01230, 0, 1, 4'b0000, 0, 20'h01230, 0);
    vecs[8]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     1, 1, 4'b0000, 0, 20'h01230, 0);
    vecs[9]  = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     2, 1, 4'b0000, 0, 20'h01230, 0);
    vecs[10] = mk(1, 20'h00048, 0, 0, 0, 0, 20'h0,     3, 1, 4'b0100, 1, 20'h00040, 0);
    vecs[11] = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     0, 1, 4'b0100, 0, 20'h00040, 0);
    vecs[12] = mk(1, 20'h00040, 0, 0, 0, 0, 20'h0,     1, 1, 4'b0101, 0, 20'h00040, 0);
    vecs[13] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     3, 1, 4'b0101, 0, 20'h00040, 0);
    vecs[14] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00045, 0, 1, 4'b0000, 0, 20'h00040, 0);
    vecs[15] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     1, 1, 4'b0000, 0, 20'h00040, 0);
    vecs[16] = mk(1, 20'h00100, 0, 0, 0, 0, 20'h0,     2, 1, 4'b0010, 1, 20'h00100, 0);
    vecs[17] = mk(1, 20'h00200, 0, 0, 0, 0, 20'h0,     3, 1, 4'b0110, 1, 20'h00100, 1);
    vecs[18] = mk(1, 20'h00300, 0, 0, 0, 0, 20'h0,     0, 1, 4'b0110, 1, 20'h00100, 1);
    vecs[19] = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     3, 1, 4'b0110, 0, 20'h00100, 1);
    vecs[20] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     0, 1, 4'b0110, 1, 20'h00200, 1);
    vecs[21] = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     3, 1, 4'b0110, 0, 20'h00200, 1);
    vecs[22] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     0, 1, 4'b0110, 0, 20'h00200, 1);
    vecs[23] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00100, 1, 1, 4'b0100, 0, 20'h00200, 0);
    vecs[24] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00200, 2, 1, 4'b0000, 0, 20'h00200, 0);
    vecs[25] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     3, 1, 4'b0000, 0, 20'h00200, 0);
    vecs[26] = mk(1, 20'h00500, 0, 0, 0, 0, 20'h0,     0, 1, 4'b1000, 1, 20'h00500, 0);
    vecs[27] = mk(0, 20'h0,     1, 3, 1, 0, 20'h0,     1, 1, 4'b0000, 0, 20'h00500, 0);
    vecs[28] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     2, 1, 4'b0000, 0, 20'h00500, 0);
    vecs[29] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     3, 1, 4'b0000, 0, 20'h00500, 0);
    vecs[30] = mk(1, 20'h00600, 1, 3, 0, 0, 20'h0,     0, 1, 4'b0000, 0, 20'h00500, 0);
    vecs[31] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00500, 1, 1, 4'b0000, 0, 20'h00500, 0);
    vecs[32] = mk(1, 20'h00700, 0, 0, 0, 0, 20'h0,     2, 1, 4'b0010, 1, 20'h00700, 0);
    vecs[33] = mk(1, 20'h00800, 0, 0, 0, 0, 20'h0,     3, 1, 4'b0110, 1, 20'h00700, 1);
    vecs[34] = mk(1, 20'h00900, 0, 0, 0, 0, 20'h0,     0, 1, 4'b0110, 1, 20'h00700, 1);
    vecs[35] = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     3, 1, 4'b0110, 0, 20'h00700, 1);
    vecs[36] = mk(0, 20'h0,     0, 0, 0, 0, 20'h0,     0, 1, 4'b0110, 1, 20'h00800, 1);
    vecs[37] = mk(0, 20'h0,     0, 0, 1, 0, 20'h0,     3, 1, 4'b0110, 0, 20'h00800, 1);
    vecs[38] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00700, 0, 1, 4'b0100, 0, 20'h00800, 0);
    vecs[39] = mk(1, 20'h00804, 0, 0, 0, 0, 20'h0,     1, 1, 4'b0101, 0, 20'h00800, 0);
    vecs[40] = mk(1, 20'h00808, 0, 0, 0, 0, 20'h0,     3, 1, 4'b0111, 0, 20'h00800, 0);
    vecs[41] = mk(1, 20'h0080C, 0, 0, 0, 0, 20'h0,     3, 0, 4'b1111, 0, 20'h00800, 0);
    vecs[42] = mk(1, 20'h00A00, 0, 0, 0, 0, 20'h0,     3, 0, 4'b1111, 0, 20'h00800, 0);
    vecs[43] = mk(0, 20'h0,     0, 0, 0, 1, 20'h00800, 0, 1, 4'b0000, 0, 20'h00800, 0);

    // Reset state while rst is held across a clock edge.
    idle_inputs();
    @(posedge clk); #1;
    check_outs(-1, 2'd3, 1'b0, 4'b0000, 1'b0, 20'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      miss_en = vecs[i].miss;  miss_addr = vecs[i].maddr;
      exc_en = vecs[i].exc;    exc_thread = vecs[i].ethr;
      mem_req_ready = vecs[i].rdy;
      mem_rec_en = vecs[i].rec; mem_rec_addr = vecs[i].raddr;
      @(posedge clk); #1;
      check_outs(i, vecs[i].ft, vecs[i].fv, vecs[i].st, vecs[i].ren, vecs[i].addr,
                 vecs[i].full);
    end

    // Async reset while a request is being presented.
    miss_en = 1'b1; miss_addr = 20'h00B07;
    @(posedge clk); #1;
    check_outs(100, 2'd1, 1'b1, 4'b0001, 1'b1, 20'h00B00, 1'b0);
    idle_inputs();
    #3 rst = 1'b1;
    #1;
    check_outs(101, 2'd3, 1'b0, 4'b0000, 1'b0, 20'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs(102, 2'd0, 1'b1, 4'b0000, 1'b0, 20'h0, 1'b0);
    // The discarded entry must not be re-presented.
    @(posedge clk); #1;
    check_outs(103, 2'd1, 1'b1, 4'b0000, 1'b0, 20'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
